bcd_cascade_counter: RTL and testbench

Parametrised multi-digit BCD counter for the stopwatch datapath. Counts up or down on a one-cycle `time_en` tick with ripple carry/borrow between digits, per-digit modulus selection (decimal or base-6 digits for mm:ss-style display), synchronous clear and parallel load. It sits between the tick prescaler and the seven-segment display multiplexer, and drives the display through an optional lap-hold register.

---
 rtl/bcd_cascade_counter.sv | 127 ++++++++++++
 tb/tb_bcd_cascade_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD up/down counter with ripple carry/borrow, per-digit mod-6/mod-10,
// clear/load, sticky wrap flag and optional lap-hold display snapshot (BCD_LAP_HOLD_EN).
module bcd_cascade_counter #(
    parameter int unsigned         DIGITS    = 4,
    parameter logic [DIGITS-1:0]   MOD6_MASK = {DIGITS{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  time_en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   cntr,
    output logic [4*DIGITS-1:0]   disp,
    output logic                  tc,
    output logic                  ovf,
    output logic                  hold
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         all_max, all_zero;
    logic         ripple;
    logic [3:0]   dig_v, dig_max;

    function automatic logic [3:0] digit_max(input int unsigned idx);
        return MOD6_MASK[idx] ? 4'd5 : 4'd9;
    endfunction

    // Terminal-count detection across all digits
    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt_q[4*i +: 4] != digit_max(i)) all_max = 1'b0;
            if (cnt_q[4*i +: 4] != 4'd0)         all_zero = 1'b0;
        end
    end

    // rst_n gate keeps tc low while the flops are held in reset
    assign tc = rst_n & time_en & ~clr & ~load & (up_dn ? all_max : all_zero);

    // Next count: clear > load (saturating) > ripple step
    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ripple  = 1'b1;
        dig_v   = 4'd0;
        dig_max = 4'd0;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                dig_v   = load_val[4*i +: 4];
                dig_max = digit_max(i);
                cnt_d[4*i +: 4] = (dig_v > dig_max) ? dig_max : dig_v;
            end
        end else if (time_en) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                dig_v   = cnt_q[4*i +: 4];
                dig_max = digit_max(i);
                if (ripple) begin
                    if (up_dn) begin
                        cnt_d[4*i +: 4] = (dig_v == dig_max) ? 4'd0 : dig_v + 4'd1;
                        ripple          = (dig_v == dig_max);
                    end else begin
                        cnt_d[4*i +: 4] = (dig_v == 4'd0) ? dig_max : dig_v - 4'd1;
                        ripple          = (dig_v == 4'd0);
                    end
                end
            end
            if (tc) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cntr = cnt_q;
    assign ovf  = ovf_q;

`ifdef BCD_LAP_HOLD_EN
    logic         hold_q, hold_d;
    logic [W-1:0] snap_q, snap_d;

    // Each lap pulse toggles hold; entering hold captures the pre-edge count
    always_comb begin
        hold_d = hold_q;
        snap_d = snap_q;
        if (lap) begin
            hold_d = ~hold_q;
            if (!hold_q) snap_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            snap_q <= '0;
        end else begin
            hold_q <= hold_d;
            snap_q <= snap_d;
        end
    end

    assign hold = hold_q;
    assign disp = hold_q ? snap_q : cnt_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign hold       = 1'b0;
    assign disp       = cnt_q;
`endif

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed self-checking bench for bcd_cascade_counter: three instances with
// different digit masks share one stimulus stream.
module tb_bcd_cascade_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        time_en, up_dn, clr, load, lap;
    logic [15:0] load_val;

    logic [15:0] cntr_a, disp_a, cntr_m, disp_m, cntr_s, disp_s;
    logic        tc_a, ovf_a, hold_a, tc_m, ovf_m, hold_m, tc_s, ovf_s, hold_s;

    int checks   = 0;
    int failures = 0;

`ifdef BCD_LAP_HOLD_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd_cascade_counter #(.DIGITS(4), .MOD6_MASK(4'b0000)) u_dec (
        .clk(clk), .rst_n(rst_n), .time_en(time_en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .lap(lap), .cntr(cntr_a), .disp(disp_a),
        .tc(tc_a), .ovf(ovf_a), .hold(hold_a));

    bcd_cascade_counter #(.DIGITS(4), .MOD6_MASK(4'b1010)) u_mmss (
        .clk(clk), .rst_n(rst_n), .time_en(time_en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .lap(lap), .cntr(cntr_m), .disp(disp_m),
        .tc(tc_m), .ovf(ovf_m), .hold(hold_m));

    bcd_cascade_counter #(.DIGITS(4), .MOD6_MASK(4'b0010)) u_sat (
        .clk(clk), .rst_n(rst_n), .time_en(time_en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .lap(lap), .cntr(cntr_s), .disp(disp_s),
        .tc(tc_s), .ovf(ovf_s), .hold(hold_s));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int k);
        return {4'((k / 1000) % 10), 4'((k / 100) % 10), 4'((k / 10) % 10), 4'(k % 10)};
    endfunction

    // Advance one clock; inputs set beforehand are stable across the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; time_en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0;
        lap = 1'b0; load_val = 16'h0;
        #3;
        chk("rst_cntr", cntr_a, 16'h0000);
        chk("rst_disp", disp_a, 16'h0000);
        chk("rst_ovf",  16'(ovf_a), 16'd0);
        chk("rst_hold", 16'(hold_a), 16'd0);
        chk("rst_tc",   16'(tc_a), 16'd0);
        step();
        time_en = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // Full-range up count on the decimal instance
        time_en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            chk("up_cntr", cntr_a, to_bcd(k));
            chk("up_tc", 16'(tc_a), 16'(k == 9999));
            if (k == 9999) chk("up_ovf_pre", 16'(ovf_a), 16'd0);
            step();
        end
        time_en = 1'b0;
        chk("up_wrap_cntr", cntr_a, 16'h0000);
        chk("up_wrap_ovf", 16'(ovf_a), 16'd1);

        // mm:ss carries
        do_load(16'h0959);
        chk("mm_load", cntr_m, 16'h0959);
        time_en = 1'b1; up_dn = 1'b1; #1;
        chk("mm_tc0", 16'(tc_m), 16'd0);
        step();
        time_en = 1'b0;
        chk("mm_carry", cntr_m, 16'h1000);
        do_load(16'h5959);
        time_en = 1'b1; #1;
        chk("mm_tc1", 16'(tc_m), 16'd1);
        step();
        time_en = 1'b0;
        chk("mm_wrap", cntr_m, 16'h0000);
        chk("mm_ovf", 16'(ovf_m), 16'd1);

        // Down count with borrow
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_cntr", cntr_a, 16'h0000);
        chk("clr_ovf", 16'(ovf_a), 16'd0);
        do_load(16'h1000);
        time_en = 1'b1; up_dn = 1'b0; #1;
        chk("dn_tc0", 16'(tc_a), 16'd0);
        step();
        time_en = 1'b0;
        chk("dn_borrow", cntr_a, 16'h0999);
        do_load(16'h0000);
        time_en = 1'b1; #1;
        chk("dn_tc1", 16'(tc_a), 16'd1);
        step();
        time_en = 1'b0;
        chk("dn_wrap", cntr_a, 16'h9999);
        chk("dn_ovf", 16'(ovf_a), 16'd1);

        // Priority: clr over load over time_en
        clr = 1'b1; load = 1'b1; time_en = 1'b1; up_dn = 1'b1; load_val = 16'h1234; #1;
        chk("prio_tc", 16'(tc_a), 16'd0);
        step();
        clr = 1'b0; load = 1'b0; time_en = 1'b0;
        chk("prio_cntr", cntr_a, 16'h0000);
        chk("prio_ovf", 16'(ovf_a), 16'd0);
        load = 1'b1; time_en = 1'b1; load_val = 16'h0005; #1;
        chk("ld_tc", 16'(tc_a), 16'd0);
        step();
        load = 1'b0; time_en = 1'b0;
        chk("ld_over_tick", cntr_a, 16'h0005);

        // Saturating load
        do_load(16'hF7F3);
        chk("sat_mask", cntr_s, 16'h9753);
        chk("sat_dec", cntr_a, 16'h9793);
        chk("sat_ovf", 16'(ovf_a), 16'd0);

        // Lap hold
        do_load(16'h0042);
        lap = 1'b1; step(); lap = 1'b0;
        chk("lap_hold1", 16'(hold_a), 16'(LAP_EN));
        chk("lap_disp1", disp_a, 16'h0042);
        time_en = 1'b1; up_dn = 1'b1;
        step(); step(); step();
        time_en = 1'b0;
        chk("lap_cntr", cntr_a, 16'h0045);
        chk("lap_disp_frozen", disp_a, LAP_EN ? 16'h0042 : 16'h0045);
        lap = 1'b1; step(); lap = 1'b0;
        chk("lap_hold0", 16'(hold_a), 16'd0);
        chk("lap_disp_track", disp_a, 16'h0045);

        // Async reset mid-count
        do_load(16'h9999);
        time_en = 1'b1; step(); time_en = 1'b0;
        do_load(16'h1234);
        lap = 1'b1; step(); lap = 1'b0;
        chk("pre_cntr", cntr_a, 16'h1234);
        chk("pre_ovf", 16'(ovf_a), 16'd1);
        chk("pre_hold", 16'(hold_a), 16'(LAP_EN));
        time_en = 1'b1; up_dn = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cntr", cntr_a, 16'h0000);
        chk("arst_disp", disp_a, 16'h0000);
        chk("arst_ovf", 16'(ovf_a), 16'd0);
        chk("arst_hold", 16'(hold_a), 16'd0);
        chk("arst_tc", 16'(tc_a), 16'd0);
        step();
        chk("arst_hold_cntr", cntr_a, 16'h0000);
        chk("arst_hold_disp", disp_a, 16'h0000);
        time_en = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_cntr", cntr_a, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
